// File: rtl/alu_pkg.sv
// Shared ALU definitions: default datapath width and the multiplier FSM state type.
package alu_pkg;

    localparam int ALU_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mul_state_e;

endpackage : alu_pkg

// File: rtl/ripple_adder.sv
// WIDTH-bit ripple-carry adder built from gate-level full adders; no carry-out.
module ripple_adder #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic [WIDTH-1:0] out
);

    // carry[i] is the carry into bit i; the carry out of the MSB is discarded.
    logic [WIDTH-1:0] carry;

    assign carry[0] = Cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign out[i] = A[i] ^ B[i] ^ carry[i];
        if (i < WIDTH - 1) begin : g_carry
            assign carry[i+1] = (A[i] & B[i]) | (carry[i] & (A[i] ^ B[i]));
        end
    end

endmodule : ripple_adder

// File: rtl/seq_multiplier.sv
// Shift-add multiplier producing the low WIDTH bits of A*B in WIDTH cycles,
// accumulating through the shared ripple adder.
module seq_multiplier
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product
);

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    mul_state_e       state_q,   state_d;
    logic [WIDTH-1:0] acc_q,     acc_d;
    logic [WIDTH-1:0] mcand_q,   mcand_d;
    logic [WIDTH-1:0] mplier_q,  mplier_d;
    logic [CNT_W-1:0] count_q,   count_d;
    logic [WIDTH-1:0] product_q, product_d;

    logic [WIDTH-1:0] addend;
    logic [WIDTH-1:0] sum;

    // Gate-level increment so the only arithmetic in this block is the adder.
    function automatic logic [CNT_W-1:0] incr(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] res;
        logic             carry;
        res   = '0;
        carry = 1'b1;
        for (int i = 0; i < CNT_W; i++) begin
            res[i] = v[i] ^ carry;
            carry  = v[i] & carry;
        end
        return res;
    endfunction

    assign addend = mplier_q[0] ? mcand_q : '0;

    ripple_adder #(.WIDTH(WIDTH)) u_adder (
        .A   (acc_q),
        .B   (addend),
        .Cin (1'b0),
        .out (sum)
    );

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path through the case infers a latch.
        state_d   = state_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        count_d   = count_q;
        product_d = product_q;

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    state_d  = RUN;
                    acc_d    = '0;
                    mcand_d  = A;
                    mplier_d = B;
                    count_d  = '0;
                end
            end
            RUN: begin
                acc_d    = sum;
                mcand_d  = {mcand_q[WIDTH-2:0], 1'b0};
                mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
                count_d  = incr(count_q);
                if (count_q == LAST_ITER) begin
                    state_d   = DONE;
                    product_d = sum;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
        if (reset) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            count_q   <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            count_q   <= count_d;
            product_q <= product_d;
        end
    end

    assign busy    = (state_q == RUN);
    assign done    = (state_q == DONE);
    assign product = product_q;

endmodule : seq_multiplier

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier: directed corner cases plus random
// operands compared against a plain-arithmetic reference product.
module tb_seq_multiplier;

    localparam int W       = 32;
    localparam int LATENCY = 32;
    localparam int BOUND   = 100;

    logic         clk;
    logic         reset;
    logic         start;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         busy;
    logic         done;
    logic [W-1:0] product;

    int n_checks = 0;
    int n_fail   = 0;

    seq_multiplier dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .A       (A),
        .B       (B),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-1:0] full;
        full = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        return full[W-1:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called just after the accepted start edge. Scrambles A/B, optionally
    // pulses start at a given RUN cycle, and waits (bounded) for done.
    task automatic wait_done(input string tag, input int inject_at,
                             output int cycles, output int busy_cycles);
        logic [W-1:0] held;
        int           moved;
        held        = product;
        moved       = 0;
        cycles      = 0;
        busy_cycles = 0;
        start       = 1'b0;
        A           = $urandom;
        B           = $urandom;
        while (!done && cycles < BOUND) begin
            if (busy) busy_cycles++;
            if (product !== held) moved++;
            if (cycles == inject_at) begin
                start = 1'b1;
                A     = 32'd100;
                B     = 32'd100;
            end else begin
                start = 1'b0;
            end
            tick();
            cycles++;
        end
        start = 1'b0;
        check({tag, "_latency"}, cycles, LATENCY);
        check({tag, "_busy_cycles"}, busy_cycles, LATENCY);
        check({tag, "_product_stable_in_run"}, moved, 0);
    endtask

    // Full operation from IDLE with a one-cycle done pulse and held product.
    task automatic do_mul(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input int inject_at);
        int cyc, bcyc;
        logic [W-1:0] exp;
        exp   = ref_mul(a, b);
        start = 1'b1;
        A     = a;
        B     = b;
        tick();
        check({tag, "_busy_after_start"}, busy, 1);
        wait_done(tag, inject_at, cyc, bcyc);
        check({tag, "_product"}, product, exp);
        check({tag, "_busy_low_in_done"}, busy, 0);
        tick();
        check({tag, "_done_single_pulse"}, done, 0);
        check({tag, "_back_to_idle"}, busy, 0);
        check({tag, "_product_held"}, product, exp);
    endtask

    initial begin
        int cyc, bcyc;
        reset = 1'b1;
        start = 1'b0;
        A     = '0;
        B     = '0;
        repeat (3) tick();
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_product", product, 0);
        reset = 1'b0;
        tick();

        do_mul("basic_3x5", 32'd3, 32'd5, -1);
        do_mul("ovf_ffff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
        do_mul("ovf_2pow16", 32'h0001_0000, 32'h0001_0000, -1);
        do_mul("identity", 32'h1234_5678, 32'd1, -1);
        do_mul("zero_a", 32'd0, 32'hDEAD_BEEF, -1);
        do_mul("busy_ignore", 32'd7, 32'd6, 10);

        // Back-to-back: start held during the DONE cycle restarts immediately.
        start = 1'b1;
        A     = 32'd7;
        B     = 32'd6;
        tick();
        wait_done("b2b_first", -1, cyc, bcyc);
        check("b2b_first_product", product, ref_mul(32'd7, 32'd6));
        start = 1'b1;
        A     = 32'd9;
        B     = 32'd9;
        tick();
        check("b2b_no_idle_bubble", busy, 1);
        check("b2b_done_dropped", done, 0);
        wait_done("b2b_second", -1, cyc, bcyc);
        check("b2b_second_product", product, ref_mul(32'd9, 32'd9));
        tick();
        check("b2b_done_single_pulse", done, 0);

        // Reset in the middle of a RUN aborts without a done pulse.
        start = 1'b1;
        A     = 32'd5;
        B     = 32'd5;
        tick();
        start = 1'b0;
        repeat (15) tick();
        check("abort_still_busy", busy, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_product", product, 0);
        begin
            int pulses = 0;
            for (int i = 0; i < 40; i++) begin
                if (done) pulses++;
                tick();
            end
            check("abort_no_done_pulse", pulses, 0);
        end
        do_mul("after_abort_2x3", 32'd2, 32'd3, -1);

        for (int i = 0; i < 8; i++) begin
            logic [W-1:0] ra, rb;
            ra = $urandom;
            rb = $urandom;
            if (i == 0) ra = 32'h8000_0000;
            if (i == 1) rb = 32'hFFFF_FFFF;
            do_mul($sformatf("rand%0d", i), ra, rb, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_seq_multiplier

// File: doc/seq_multiplier.md
Name: seq_multiplier

Overview:
- Multi-cycle shift-add multiplier; produces the low WIDTH bits of A*B (unsigned; identical for two's-complement low word).
- Sits directly upstream and downstream of the existing 32-bit ripple adder: drives the adder's A/B/Cin each cycle and registers the adder's out as the running accumulator.
- Used by the ALU for the multiply operation; start/done handshake to the control unit.

Parameters:
WIDTH, 32, operand, adder and product width in bits
CNT_W, 6, iteration counter width; must satisfy 2**CNT_W > WIDTH

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high; returns block to IDLE
start  input  1  request a multiply; sampled only in IDLE or DONE
A  input  WIDTH  multiplicand, captured on the accepted start edge
B  input  WIDTH  multiplier, captured on the accepted start edge
busy  output  1  high while in RUN
done  output  1  one-cycle pulse, high only in DONE
product  output  WIDTH  low WIDTH bits of A*B; valid while done is high, then held

Behaviour:
- Reset (sync, active-high, priority over everything): state=IDLE, acc=0, mcand=0, mplier=0, count=0, product=0, busy=0, done=0.
- Reset asserted mid-RUN aborts the operation; product returns to 0 and no done pulse is produced.
- States: IDLE, RUN, DONE.
- IDLE: start=1 at an edge -> RUN; acc<=0, mcand<=A, mplier<=B, count<=0.
- RUN, every edge:
  - acc<=adder.out, where the adder inputs are A=acc, B=(mplier[0] ? mcand : 0), Cin=0;
  - mcand<=mcand<<1 (zero fill); mplier<=mplier>>1 (logical); count<=count+1.
- RUN exit: on the edge where count==WIDTH-1, go to DONE and load product<=adder.out. The final accumulate goes to product, not only to acc.
- DONE: done=1 for exactly one cycle.
  - start=1 -> RUN, loading exactly as from IDLE (back-to-back operation, no idle bubble).
  - Otherwise -> IDLE.
- start in RUN is ignored; A and B are not re-captured mid-operation.
- Latency: start accepted at edge 0 -> done high during the cycle after edge WIDTH (32 for the default). Fixed, with no early termination on zero operands.
- Arithmetic is modulo 2**WIDTH. The adder has no carry-out; overflow bits are discarded, and that is the required result.
- product changes only when entering DONE or on reset; it is stable in IDLE and RUN.
- busy and done are decoded from state, never both high.
- A and B may change freely after the accepted start edge.

Decomposition:
- Shared package (alu_pkg): state enum type (IDLE, RUN, DONE; 2-bit encoding) and the default WIDTH constant.
- One sub-module: the existing adder (ports out, A, B, Cin), instantiated once with Cin tied to 0. No behavioural "+" is allowed in this block.
- Shifting, muxing, counter and FSM stay in seq_multiplier.

Test Plan:
- Basic: A=3, B=5, pulse start -> busy high for 32 cycles; done pulses once exactly 32 edges after the start edge; product=15.
- Overflow/identity: A=0xFFFFFFFF, B=0xFFFFFFFF -> product=0x00000001. A=0x00010000, B=0x00010000 -> product=0x00000000. A=0x12345678, B=1 -> product=0x12345678.
- Zero operand: A=0, B=0xDEADBEEF -> product=0, still full 32-cycle latency.
- Busy-ignore: start A=7, B=6; at RUN cycle 10 drive start=1 with A=100, B=100 -> product=42; done pulses exactly once.
- Back-to-back: hold start high in the DONE cycle with A=9, B=9, after 7*6 -> done for 42, then RUN immediately with no IDLE cycle; next done gives product=81.
- Reset mid-op: A=5, B=5; assert reset at RUN cycle 15 -> next edge: state IDLE, busy=0, product=0, no done pulse. A fresh start with A=2, B=3 -> product=6.
